cache_refill_ctrl: RTL

Single-outstanding miss handler that sits directly in front of the generic N-way cache and owns its read, write and refill ports. It accepts one read request at a time, performs a cache lookup, and returns cached data on a hit. On a miss it fetches the word from backing memory through a req/ack handshake, writes it into the cache, and returns it to the requester. It also keeps saturating hit and miss counters for performance monitoring.

---
 rtl/cache_refill_ctrl_if.sv | 55 +++++
 rtl/cache_refill_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl_if.sv
// ---------------------------------------------------------------------------
// cache_refill_ctrl_if
// Bundles every bus that the refill controller touches.
//   Requester side : req_valid/req_addr/req_ready, resp_valid/resp_data/
//                    resp_err/resp_ready
//   Cache side     : cache_re/cache_read_addr/cache_out/cache_hit,
//                    cache_we/cache_write_addr/cache_in
//   Memory side    : mem_req/mem_addr/mem_ack/mem_rdata
// Modports:
//   slave  - the refill controller's view
//   master - the environment's view (requester, cache and memory together)
// ---------------------------------------------------------------------------
interface cache_refill_ctrl_if #(
    parameter int CACHE_DATA_WIDTH = 8,
    parameter int CACHE_ADDR_WIDTH = 8
);
    logic                        req_valid;
    logic [CACHE_ADDR_WIDTH-1:0] req_addr;
    logic                        req_ready;
    logic                        resp_valid;
    logic [CACHE_DATA_WIDTH-1:0] resp_data;
    logic                        resp_err;
    logic                        resp_ready;

    logic                        cache_re;
    logic [CACHE_ADDR_WIDTH-1:0] cache_read_addr;
    logic [CACHE_DATA_WIDTH-1:0] cache_out;
    logic                        cache_hit;
    logic                        cache_we;
    logic [CACHE_ADDR_WIDTH-1:0] cache_write_addr;
    logic [CACHE_DATA_WIDTH-1:0] cache_in;

    logic                        mem_req;
    logic [CACHE_ADDR_WIDTH-1:0] mem_addr;
    logic                        mem_ack;
    logic [CACHE_DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_addr, resp_ready,
        input  cache_out, cache_hit,
        input  mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_data, resp_err,
        output cache_re, cache_read_addr, cache_we, cache_write_addr, cache_in,
        output mem_req, mem_addr
    );

    modport master (
        output req_valid, req_addr, resp_ready,
        output cache_out, cache_hit,
        output mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  cache_re, cache_read_addr, cache_we, cache_write_addr, cache_in,
        input  mem_req, mem_addr
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// cache_refill_ctrl
// Single-outstanding miss handler in front of an N-way cache. Accepts one
// read request, looks it up in the cache, answers hits directly and, on a
// miss, fetches the word from memory, writes it into the cache and answers.
// A memory that does not acknowledge within TIMEOUT cycles yields an error
// response with zero data and no cache fill.
// Ports:
//   clk        - clock, rising edge
//   rstn       - asynchronous active-low reset
//   bus        - requester / cache / memory buses (slave modport)
//   hit_count  - saturating hit counter
//   miss_count - saturating miss counter
// All bus outputs are decoded from registers only (Moore style).
// ---------------------------------------------------------------------------
module cache_refill_ctrl #(
    parameter int CACHE_DATA_WIDTH = 8,
    parameter int CACHE_ADDR_WIDTH = 8,
    parameter int TIMEOUT          = 16,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    cache_refill_ctrl_if.slave   bus,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    localparam int               TO_W    = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        CHECK,
        FETCH,
        FILL,
        RESP
    } state_t;

    state_t                      state;
    state_t                      state_nx;
    logic [CACHE_ADDR_WIDTH-1:0] addr_r;
    logic [CACHE_DATA_WIDTH-1:0] data_r;
    logic                        err_r;
    logic [TO_W-1:0]             to_cnt;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.req_valid) state_nx = LOOKUP;
            LOOKUP:  state_nx = CHECK;
            CHECK:   state_nx = bus.cache_hit ? RESP : FETCH;
            // An ack on the last allowed cycle still wins over the timeout.
            FETCH: begin
                if (bus.mem_ack) begin
                    state_nx = FILL;
                end else if (to_cnt == TO_LAST) begin
                    state_nx = RESP;
                end
            end
            FILL:    state_nx = RESP;
            RESP:    if (bus.resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Address, data, error and timeout registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_r <= '0;
            data_r <= '0;
            err_r  <= 1'b0;
            to_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) addr_r <= bus.req_addr;
                end
                CHECK: begin
                    if (bus.cache_hit) begin
                        data_r <= bus.cache_out;
                    end else begin
                        to_cnt <= '0;
                    end
                end
                FETCH: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (bus.mem_ack) begin
                        data_r <= bus.mem_rdata;
                    end else if (to_cnt == TO_LAST) begin
                        data_r <= '0;
                        err_r  <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) err_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Performance counters stick at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == CHECK) begin
            if (bus.cache_hit) begin
                if (hit_count != '1) hit_count <= hit_count + 1'b1;
            end else begin
                if (miss_count != '1) miss_count <= miss_count + 1'b1;
            end
        end
    end

    // Moore output decode
    assign bus.req_ready        = (state == IDLE);
    assign bus.cache_re         = (state == LOOKUP);
    assign bus.mem_req          = (state == FETCH);
    assign bus.cache_we         = (state == FILL);
    assign bus.resp_valid       = (state == RESP);
    assign bus.resp_err         = err_r;
    assign bus.resp_data        = data_r;
    assign bus.cache_read_addr  = addr_r;
    assign bus.cache_write_addr = addr_r;
    assign bus.mem_addr         = addr_r;
    assign bus.cache_in         = data_r;

endmodule
